// File: rtl/exec_mc_if.sv
// Handshake and result bus between ID and the exec_mc execute stage.
// ID drives the master side; exec_mc takes the slave side.
interface exec_mc_if #(
    parameter int W_WORD = 32,
    parameter int W_RD   = 5
);
    logic              v_i;
    logic              stall_o;
    logic [W_WORD-1:0] src_i;
    logic [W_WORD-1:0] dest_i;
    logic              wb_i;
    logic [W_RD-1:0]   rd_num_i;
    logic [3:0]        cls_i;
    logic [1:0]        opc_i;
    logic              v_o;
    logic              wb_o;
    logic [W_RD-1:0]   rd_num_o;
    logic [W_WORD-1:0] rd_data_o;
    logic [3:0]        status_o;

    modport master (
        output v_i, src_i, dest_i, wb_i, rd_num_i, cls_i, opc_i,
        input  stall_o, v_o, wb_o, rd_num_o, rd_data_o, status_o
    );

    modport slave (
        input  v_i, src_i, dest_i, wb_i, rd_num_i, cls_i, opc_i,
        output stall_o, v_o, wb_o, rd_num_o, rd_data_o, status_o
    );
endinterface

// File: rtl/exec_mc.sv
// Execute stage: single-cycle add/sub/shift/logic, iterative shift-add multiplier.
//
// state | meaning
// IDLE  | accepting instructions; single-cycle ops complete on the accepting edge
// BUSY  | multiplying one multiplier bit per cycle; stall_o high, inputs ignored
module exec_mc #(
    parameter int W_WORD = 32,
    parameter int W_RD   = 5,
    parameter int MUL_EN = 1
) (
    input logic      clk,
    input logic      rst,
    exec_mc_if.slave bus
);
    localparam int         W_SH      = $clog2(W_WORD);
    localparam logic [3:0] CLS_INTE  = 4'b1000;
    localparam logic [3:0] CLS_SHIFT = 4'b0100;
    localparam logic [3:0] CLS_LOGIC = 4'b0010;
    localparam logic [3:0] CLS_MUL   = 4'b0001;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nx;

    logic [W_SH-1:0]   cnt;
    logic [W_WORD-1:0] mcand, acc_hi, acc_lo;
    logic              m_hi, m_wb;
    logic [W_RD-1:0]   m_rd;

    logic              v_q, wb_q;
    logic [W_RD-1:0]   rd_q;
    logic [W_WORD-1:0] data_q;
    logic [3:0]        status_q;

    logic                accept, mul_start, op_ok, op_cmp, res_c, res_v, mul_done;
    logic [W_SH-1:0]     amt;
    logic [W_WORD-1:0]   res, step_hi, step_lo, mul_res;
    logic [W_WORD:0]     add_r, sub_r, sll_r, srl_r, step_sum;
    logic signed [W_WORD:0] sra_r;

    assign accept = bus.v_i && (state == IDLE);

    // Shifts carry one extra bit so the last bit shifted out falls into it
    always_comb begin
        amt       = bus.src_i[W_SH-1:0];
        add_r     = {1'b0, bus.dest_i} + {1'b0, bus.src_i};
        sub_r     = {1'b0, bus.dest_i} - {1'b0, bus.src_i};
        sll_r     = {1'b0, bus.dest_i} << amt;
        srl_r     = {bus.dest_i, 1'b0} >> amt;
        sra_r     = $signed({bus.dest_i, 1'b0}) >>> amt;
        res       = '0;
        res_c     = 1'b0;
        res_v     = 1'b0;
        op_ok     = 1'b0;
        op_cmp    = 1'b0;
        mul_start = 1'b0;
        case (bus.cls_i)
            CLS_INTE: begin
                op_ok  = (bus.opc_i != 2'd3);
                op_cmp = (bus.opc_i == 2'd2);
                if (bus.opc_i == 2'd0) begin
                    {res_c, res} = add_r;
                    res_v = (bus.dest_i[W_WORD-1] == bus.src_i[W_WORD-1]) &&
                            (res[W_WORD-1] != bus.dest_i[W_WORD-1]);
                end else begin
                    {res_c, res} = sub_r;
                    res_v = (bus.dest_i[W_WORD-1] != bus.src_i[W_WORD-1]) &&
                            (res[W_WORD-1] != bus.dest_i[W_WORD-1]);
                end
            end
            CLS_SHIFT: begin
                op_ok = (bus.opc_i != 2'd3);
                case (bus.opc_i)
                    2'd0:    {res_c, res} = sll_r;
                    2'd1:    {res, res_c} = srl_r;
                    default: {res, res_c} = sra_r;
                endcase
            end
            CLS_LOGIC: begin
                op_ok = 1'b1;
                case (bus.opc_i)
                    2'd0:    res = bus.dest_i & bus.src_i;
                    2'd1:    res = bus.dest_i | bus.src_i;
                    2'd2:    res = bus.dest_i ^ bus.src_i;
                    default: res = ~bus.dest_i;
                endcase
            end
            CLS_MUL:  mul_start = (MUL_EN != 0) && !bus.opc_i[1];
            default:  ;
        endcase
    end

    // {acc_hi, acc_lo} shifts right each step; acc_lo starts as the multiplier
    always_comb begin
        step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        step_hi  = step_sum[W_WORD:1];
        step_lo  = {step_sum[0], acc_lo[W_WORD-1:1]};
        mul_done = (state == BUSY) && (cnt == '0);
        mul_res  = m_hi ? step_hi : step_lo;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && mul_start) state_nx = BUSY;
            BUSY:    if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            m_hi     <= 1'b0;
            m_wb     <= 1'b0;
            m_rd     <= '0;
            v_q      <= 1'b0;
            wb_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            v_q  <= 1'b0;
            wb_q <= 1'b0;
            if (state == BUSY) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt - W_SH'(1);
                if (mul_done) begin
                    v_q      <= 1'b1;
                    wb_q     <= m_wb;
                    rd_q     <= m_rd;
                    data_q   <= mul_res;
                    status_q <= {mul_res[W_WORD-1], mul_res == '0, 2'b00};
                end
            end else if (accept) begin
                if (mul_start) begin
                    mcand  <= bus.dest_i;
                    acc_hi <= '0;
                    acc_lo <= bus.src_i;
                    cnt    <= W_SH'(W_WORD - 1);
                    m_hi   <= bus.opc_i[0];
                    m_wb   <= bus.wb_i;
                    m_rd   <= bus.rd_num_i;
                end else if (op_ok) begin
                    v_q      <= 1'b1;
                    wb_q     <= bus.wb_i && !op_cmp;
                    rd_q     <= bus.rd_num_i;
                    data_q   <= res;
                    status_q <= {res[W_WORD-1], res == '0, res_c, res_v};
                end
            end
        end
    end

    assign bus.stall_o   = (state == BUSY);
    assign bus.v_o       = v_q;
    assign bus.wb_o      = wb_q;
    assign bus.rd_num_o  = rd_q;
    assign bus.rd_data_o = data_q;
    assign bus.status_o  = status_q;
endmodule

// File: tb/tb_exec_mc.sv
// Bench for exec_mc: directed test-plan steps and random ops against an
// arithmetic reference model; a second instance covers MUL_EN=0.
module tb_exec_mc;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic [3:0]  exp_status;

    exec_mc_if #(.W_WORD(32), .W_RD(5)) bus ();
    exec_mc_if #(.W_WORD(32), .W_RD(5)) bus_nm ();

    exec_mc #(.W_WORD(32), .W_RD(5), .MUL_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exec_mc #(.W_WORD(32), .W_RD(5), .MUL_EN(0)) dut_nm (
        .clk (clk),
        .rst (rst),
        .bus (bus_nm.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [31:0] x);
        return longint'($signed(x));
    endfunction

    // Reference behaviour from plain arithmetic on wide integers
    task automatic ref_op(input logic [3:0] cls, input logic [1:0] opc,
                          input logic [31:0] s, input logic [31:0] d,
                          output bit ok, output bit is_mul, output bit is_cmp,
                          output logic [31:0] r, output logic c, output logic v);
        logic [63:0]        wide;
        longint             sw;
        int                 amt;
        logic signed [31:0] sd;
        ok = 0; is_mul = 0; is_cmp = 0; r = '0; c = 1'b0; v = 1'b0;
        amt = int'(s[4:0]);
        sd  = d;
        case (cls)
            4'b1000: begin
                if (opc == 2'd0) begin
                    ok = 1; wide = {32'b0, d} + {32'b0, s};
                    r = wide[31:0]; c = wide[32];
                    sw = sx(d) + sx(s);
                end else if (opc != 2'd3) begin
                    ok = 1; is_cmp = (opc == 2'd2);
                    r = d - s; c = (d < s);
                    sw = sx(d) - sx(s);
                end
                if (ok) v = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
            end
            4'b0100: begin
                ok = (opc != 2'd3);
                if (opc == 2'd0) begin
                    r = d << amt; c = (amt == 0) ? 1'b0 : d[32-amt];
                end else begin
                    r = (opc == 2'd1) ? (d >> amt) : 32'(sd >>> amt);
                    c = (amt == 0) ? 1'b0 : d[amt-1];
                end
            end
            4'b0010: begin
                ok = 1;
                case (opc)
                    2'd0: r = d & s;
                    2'd1: r = d | s;
                    2'd2: r = d ^ s;
                    default: r = ~d;
                endcase
            end
            4'b0001: begin
                if (opc < 2'd2) begin
                    ok = 1; is_mul = 1;
                    wide = {32'b0, d} * {32'b0, s};
                    r = (opc == 2'd0) ? wide[31:0] : wide[63:32];
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic ewb);
        check({tag, " v_o"},       bus.v_o, ev);
        check({tag, " wb_o"},      bus.wb_o, ewb);
        check({tag, " rd_num_o"},  bus.rd_num_o, exp_rd);
        check({tag, " rd_data_o"}, bus.rd_data_o, exp_data);
        check({tag, " status_o"},  bus.status_o, exp_status);
    endtask

    // Issue one instruction and check its completion; MUL waits out the stall
    task automatic run_op(input string tag, input logic [3:0] cls, input logic [1:0] opc,
                          input logic [31:0] s, input logic [31:0] d,
                          input logic wb, input logic [4:0] rd);
        bit          ok, is_mul, is_cmp;
        logic [31:0] r;
        logic        c, v;
        int          n;
        ref_op(cls, opc, s, d, ok, is_mul, is_cmp, r, c, v);
        bus.v_i = 1'b1; bus.cls_i = cls; bus.opc_i = opc;
        bus.src_i = s; bus.dest_i = d; bus.wb_i = wb; bus.rd_num_i = rd;
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        if (is_mul) begin
            n = 0;
            while (bus.stall_o === 1'b1 && n < 40) begin
                check({tag, " busy v_o"}, bus.v_o, 1'b0);
                if (n == 5) begin
                    bus.v_i = 1'b1; bus.cls_i = 4'b1000; bus.opc_i = 2'd0;
                end else begin
                    bus.v_i = 1'b0;
                end
                n++;
                @(posedge clk); #1;
            end
            bus.v_i = 1'b0;
            check({tag, " stall cycles"}, n, 32);
        end
        if (ok) begin
            exp_data   = r;
            exp_rd     = rd;
            exp_status = {r[31], r == 32'h0, c, v};
        end
        check_outputs(tag, ok, ok && wb && !is_cmp);
    endtask

    initial begin
        logic [3:0]  rcls;
        logic [31:0] rs, rdst;
        checks = 0;
        errors = 0;
        {bus.v_i, bus.src_i, bus.dest_i, bus.wb_i, bus.rd_num_i, bus.cls_i, bus.opc_i} = '0;
        {bus_nm.v_i, bus_nm.src_i, bus_nm.dest_i, bus_nm.wb_i, bus_nm.rd_num_i,
         bus_nm.cls_i, bus_nm.opc_i} = '0;
        exp_data = '0; exp_rd = '0; exp_status = '0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall_o", bus.stall_o, 1'b0);
        check_outputs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("add ovf", 4'b1000, 2'd0, 32'h1, 32'h7FFF_FFFF, 1'b1, 5'd3);
        check("add literal data", bus.rd_data_o, 32'h8000_0000);
        check("add literal nzcv", bus.status_o, 4'b1001);
        run_op("cmp eq", 4'b1000, 2'd2, 32'd5, 32'd5, 1'b1, 5'd7);
        check("cmp literal nzcv", bus.status_o, 4'b0100);
        run_op("sub neg", 4'b1000, 2'd1, 32'd5, 32'd3, 1'b1, 5'd8);
        check("sub literal nzcv", bus.status_o, 4'b1010);
        run_op("sra by1", 4'b0100, 2'd2, 32'd1, 32'h8000_0001, 1'b1, 5'd9);
        run_op("sll by0", 4'b0100, 2'd0, 32'h20, 32'hDEAD_BEEF, 1'b1, 5'd10);
        run_op("mul lo", 4'b0001, 2'd0, 32'd2, 32'hFFFF_FFFF, 1'b1, 5'd11);
        check("mul lo literal", bus.rd_data_o, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("after mul v_o", bus.v_o, 1'b0);
        run_op("mul hi", 4'b0001, 2'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 5'd12);
        check("mul hi literal", bus.rd_data_o, 32'h0000_0001);
        run_op("bad cls 0110", 4'b0110, 2'd0, 32'd1, 32'd2, 1'b1, 5'd13);
        run_op("bad cls 0000", 4'b0000, 2'd0, 32'd1, 32'd2, 1'b1, 5'd14);
        run_op("bad inte opc", 4'b1000, 2'd3, 32'd1, 32'd2, 1'b1, 5'd15);
        run_op("bad mul opc", 4'b0001, 2'd2, 32'd1, 32'd2, 1'b1, 5'd16);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: rcls = 4'b1000;
                1: rcls = 4'b0100;
                2: rcls = 4'b0010;
                3: rcls = (i % 4 == 0) ? 4'b0001 : 4'b1000;
                default: rcls = 4'($urandom_range(0, 15));
            endcase
            rs   = $urandom();
            rdst = $urandom();
            if (i % 7 == 0) rdst = 32'h8000_0000;
            if (i % 9 == 0) rs = rdst;
            run_op("random", rcls, 2'($urandom_range(0, 3)), rs, rdst,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        bus.v_i = 1'b1; bus.cls_i = 4'b0001; bus.opc_i = 2'd0;
        bus.src_i = 32'h1234_5678; bus.dest_i = 32'h9ABC_DEF0; bus.rd_num_i = 5'd21;
        @(posedge clk); #1;
        bus.v_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_data = '0; exp_rd = '0; exp_status = '0;
        check("midmul reset stall_o", bus.stall_o, 1'b0);
        check_outputs("midmul reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op("add after reset", 4'b1000, 2'd0, 32'd40, 32'd2, 1'b1, 5'd4);

        bus_nm.v_i = 1'b1; bus_nm.cls_i = 4'b0001; bus_nm.opc_i = 2'd0;
        bus_nm.src_i = 32'd3; bus_nm.dest_i = 32'd4; bus_nm.wb_i = 1'b1; bus_nm.rd_num_i = 5'd5;
        @(posedge clk); #1;
        check("nomul stall_o", bus_nm.stall_o, 1'b0);
        check("nomul v_o", bus_nm.v_o, 1'b0);
        check("nomul wb_o", bus_nm.wb_o, 1'b0);
        check("nomul status", bus_nm.status_o, 4'b0000);
        bus_nm.cls_i = 4'b1000;
        @(posedge clk); #1;
        bus_nm.v_i = 1'b0;
        check("nomul add v_o", bus_nm.v_o, 1'b1);
        check("nomul add data", bus_nm.rd_data_o, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
